// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the execute-stage branch resolver and the BTB update path.
package branch_pkg;

    localparam int PC_W        = 16;
    localparam int INSTR_BYTES = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    // BTB update record, same layout as the predictor's update port
    typedef struct packed {
        logic            jump;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] pc;
    } btb_update_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Redirect handshake between the resolver (master) and fetch (slave).
interface branch_resolver_if #(
    parameter int PC_W = branch_pkg::PC_W
);

    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );

endinterface

// File: rtl/branch_resolver_sat_counter.sv
// Saturating up-counter used for branch statistics.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stick at all-ones, clear on reset or clear
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: checks the fetch prediction against the real
// outcome, flushes and redirects fetch on a mispredict, and issues BTB updates.
module branch_resolver #(
    parameter int PC_W          = branch_pkg::PC_W,
    parameter int INSTR_BYTES   = branch_pkg::INSTR_BYTES,
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_execute,
    input  logic                is_branch,
    input  logic [PC_W-1:0]     branch_pc,
    input  logic                pred_taken,
    input  logic [PC_W-1:0]     pred_pc,
    input  logic                actual_taken,
    input  logic [PC_W-1:0]     actual_target,
    output logic                flush,
    branch_resolver_if.master   rdr,
    output logic                upd_valid,
    output logic [PC_W-1:0]     upd_pc,
    output logic                upd_jump,
    output logic [PC_W-1:0]     upd_target,
    output logic [CNT_W-1:0]    branch_cnt,
    output logic [CNT_W-1:0]    mispred_cnt,
    output logic                busy
);

    import branch_pkg::*;

    localparam int SQ_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

    state_t            state, state_n;
    logic [SQ_W-1:0]   sq_cnt, sq_cnt_n;

    logic              resolve;
    logic              mispredict;
    logic [PC_W-1:0]   correct_pc;

    logic              flush_n;
    logic              rv_n;
    logic [PC_W-1:0]   rpc_n;
    logic              upd_valid_n;
    btb_update_t       upd_q, upd_n;
    logic              busy_n;

    // pred_taken is carried for the record; the next-PC compare alone decides
    logic              unused_pred_taken;
    assign unused_pred_taken = pred_taken;

    // Resolve and compare: only an IDLE resolver looks at execute
    always_comb begin
        resolve    = valid_execute & is_branch & (state == IDLE);
        correct_pc = actual_taken ? actual_target : (branch_pc + PC_W'(INSTR_BYTES));
        mispredict = resolve & (pred_pc != correct_pc);
    end

    // Next-state and next-output logic for the redirect FSM
    always_comb begin
        state_n     = state;
        sq_cnt_n    = sq_cnt;
        flush_n     = 1'b0;
        rv_n        = rdr.redirect_valid;
        rpc_n       = rdr.redirect_pc;
        upd_valid_n = resolve;
        upd_n       = upd_q;

        if (resolve) begin
            upd_n.jump   = actual_taken;
            upd_n.target = actual_target;
            upd_n.pc     = branch_pc;
        end

        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_n = REDIRECT;
                    flush_n = 1'b1;
                    rv_n    = 1'b1;
                    rpc_n   = correct_pc;
                end
            end
            REDIRECT: begin
                if (rdr.redirect_valid && rdr.redirect_ready) begin
                    rv_n = 1'b0;
                    if (SQUASH_CYCLES == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n  = SQUASH;
                        sq_cnt_n = SQ_W'(SQUASH_CYCLES - 1);
                    end
                end
            end
            SQUASH: begin
                if (sq_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    sq_cnt_n = sq_cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs; reset drops any pending redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            sq_cnt             <= '0;
            flush              <= 1'b0;
            rdr.redirect_valid <= 1'b0;
            rdr.redirect_pc    <= '0;
            upd_valid          <= 1'b0;
            upd_q              <= '0;
            busy               <= 1'b0;
        end else begin
            state              <= state_n;
            sq_cnt             <= sq_cnt_n;
            flush              <= flush_n;
            rdr.redirect_valid <= rv_n;
            rdr.redirect_pc    <= rpc_n;
            upd_valid          <= upd_valid_n;
            upd_q              <= upd_n;
            busy               <= busy_n;
        end
    end

    assign upd_pc     = upd_q.pc;
    assign upd_jump   = upd_q.jump;
    assign upd_target = upd_q.target;

    sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (resolve),
        .count (branch_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (mispredict),
        .count (mispred_cnt)
    );

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_execute;
    logic        is_branch;
    logic [15:0] branch_pc;
    logic        pred_taken;
    logic [15:0] pred_pc;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        flush;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_jump;
    logic [15:0] upd_target;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_br = 0;
    int exp_mp = 0;

    branch_resolver_if #(.PC_W(16)) rif ();

    branch_resolver #(
        .PC_W(16), .INSTR_BYTES(2), .SQUASH_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_execute (valid_execute),
        .is_branch     (is_branch),
        .branch_pc     (branch_pc),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .actual_taken  (actual_taken),
        .actual_target (actual_target),
        .flush         (flush),
        .rdr           (rif),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_jump      (upd_jump),
        .upd_target    (upd_target),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic [15:0] pc,
                         input logic pt, input logic [15:0] ppc,
                         input logic at, input logic [15:0] tgt);
        valid_execute = v;
        is_branch     = b;
        branch_pc     = pc;
        pred_taken    = pt;
        pred_pc       = ppc;
        actual_taken  = at;
        actual_target = tgt;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rif.redirect_ready = 1'b0;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        n_cmp++;
        if ({flush, rif.redirect_valid, upd_valid, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0000", {flush, rif.redirect_valid, upd_valid, busy});
        end
        n_cmp++;
        if ({branch_cnt, mispred_cnt, rif.redirect_pc, upd_pc, upd_target} !== 80'h0) begin
            n_bad++;
            $display("FAIL reset_values got %h want 0", {branch_cnt, mispred_cnt, rif.redirect_pc, upd_pc, upd_target});
        end
    endtask

    task automatic test_correct_nt();
        drive(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0012, 1'b0, 16'h0099);
        step();
        idle_inputs();
        exp_br++;
        n_cmp++;
        if ({upd_valid, upd_jump, flush, busy} !== 4'b1000) begin
            n_bad++;
            $display("FAIL nt_flags got %b want 1000", {upd_valid, upd_jump, flush, busy});
        end
        n_cmp++;
        if (upd_pc !== 16'h0010 || upd_target !== 16'h0099) begin
            n_bad++;
            $display("FAIL nt_upd got pc=%h tgt=%h want 0010 0099", upd_pc, upd_target);
        end
        n_cmp++;
        if (branch_cnt !== 16'(exp_br) || mispred_cnt !== 16'(exp_mp)) begin
            n_bad++;
            $display("FAIL nt_cnt got %0d/%0d want %0d/%0d", branch_cnt, mispred_cnt, exp_br, exp_mp);
        end
        step();
        n_cmp++;
        if (upd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL nt_upd_pulse got %b want 0", upd_valid);
        end
    endtask

    task automatic test_non_branch();
        drive(1'b1, 1'b0, 16'h0100, 1'b0, 16'h5555, 1'b1, 16'h0200);
        step();
        step();
        idle_inputs();
        n_cmp++;
        if ({upd_valid, flush, rif.redirect_valid, busy} !== 4'b0000 ||
            branch_cnt !== 16'(exp_br) || mispred_cnt !== 16'(exp_mp)) begin
            n_bad++;
            $display("FAIL non_branch got flags=%b cnt=%0d/%0d want 0000 %0d/%0d",
                     {upd_valid, flush, rif.redirect_valid, busy}, branch_cnt, mispred_cnt, exp_br, exp_mp);
        end
    endtask

    task automatic test_dir_mispred();
        drive(1'b1, 1'b1, 16'h0020, 1'b0, 16'h0022, 1'b1, 16'h0040);
        step();
        idle_inputs();
        exp_br++;
        exp_mp++;
        n_cmp++;
        if ({flush, rif.redirect_valid, busy, upd_valid, upd_jump} !== 5'b11111 || rif.redirect_pc !== 16'h0040) begin
            n_bad++;
            $display("FAIL dir_first got flags=%b rpc=%h want 11111 0040",
                     {flush, rif.redirect_valid, busy, upd_valid, upd_jump}, rif.redirect_pc);
        end
        n_cmp++;
        if (branch_cnt !== 16'(exp_br) || mispred_cnt !== 16'(exp_mp)) begin
            n_bad++;
            $display("FAIL dir_cnt got %0d/%0d want %0d/%0d", branch_cnt, mispred_cnt, exp_br, exp_mp);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({flush, rif.redirect_valid, busy, upd_valid} !== 4'b0110 || rif.redirect_pc !== 16'h0040) begin
                n_bad++;
                $display("FAIL dir_hold[%0d] got flags=%b rpc=%h want 0110 0040",
                         i, {flush, rif.redirect_valid, busy, upd_valid}, rif.redirect_pc);
            end
        end
        rif.redirect_ready = 1'b1;
        step();
        rif.redirect_ready = 1'b0;
        n_cmp++;
        if ({rif.redirect_valid, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL dir_squash0 got %b want 01", {rif.redirect_valid, busy});
        end
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL dir_squash1 got busy=%b want 1", busy);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL dir_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_target_and_wrong_path();
        drive(1'b1, 1'b1, 16'h0030, 1'b1, 16'h0050, 1'b1, 16'h0060);
        step();
        exp_br++;
        exp_mp++;
        n_cmp++;
        if ({flush, rif.redirect_valid} !== 2'b11 || rif.redirect_pc !== 16'h0060 || mispred_cnt !== 16'(exp_mp)) begin
            n_bad++;
            $display("FAIL tgt_mispred got flags=%b rpc=%h mp=%0d want 11 0060 %0d",
                     {flush, rif.redirect_valid}, rif.redirect_pc, mispred_cnt, exp_mp);
        end
        // wrong-path branch held through REDIRECT and SQUASH
        drive(1'b1, 1'b1, 16'h0080, 1'b0, 16'h0082, 1'b1, 16'h0300);
        step();
        n_cmp++;
        if ({upd_valid, flush, rif.redirect_valid} !== 3'b001 || rif.redirect_pc !== 16'h0060 ||
            branch_cnt !== 16'(exp_br) || mispred_cnt !== 16'(exp_mp)) begin
            n_bad++;
            $display("FAIL wp_redirect got flags=%b rpc=%h cnt=%0d/%0d want 001 0060 %0d/%0d",
                     {upd_valid, flush, rif.redirect_valid}, rif.redirect_pc, branch_cnt, mispred_cnt, exp_br, exp_mp);
        end
        rif.redirect_ready = 1'b1;
        step();
        rif.redirect_ready = 1'b0;
        step();
        n_cmp++;
        if ({upd_valid, flush, rif.redirect_valid, busy} !== 4'b0001 ||
            branch_cnt !== 16'(exp_br) || mispred_cnt !== 16'(exp_mp)) begin
            n_bad++;
            $display("FAIL wp_squash got flags=%b cnt=%0d/%0d want 0001 %0d/%0d",
                     {upd_valid, flush, rif.redirect_valid, busy}, branch_cnt, mispred_cnt, exp_br, exp_mp);
        end
        step();
        idle_inputs();
        n_cmp++;
        if ({upd_valid, flush, busy} !== 3'b000 || branch_cnt !== 16'(exp_br)) begin
            n_bad++;
            $display("FAIL wp_exit got flags=%b br=%0d want 000 %0d", {upd_valid, flush, busy}, branch_cnt, exp_br);
        end
    endtask

    task automatic test_ready_early();
        rif.redirect_ready = 1'b1;
        drive(1'b1, 1'b1, 16'h0400, 1'b1, 16'h0500, 1'b0, 16'h0500);
        step();
        idle_inputs();
        exp_br++;
        exp_mp++;
        n_cmp++;
        if ({flush, rif.redirect_valid} !== 2'b11 || rif.redirect_pc !== 16'h0402) begin
            n_bad++;
            $display("FAIL early_first got flags=%b rpc=%h want 11 0402", {flush, rif.redirect_valid}, rif.redirect_pc);
        end
        step();
        rif.redirect_ready = 1'b0;
        n_cmp++;
        if ({flush, rif.redirect_valid, busy} !== 3'b001) begin
            n_bad++;
            $display("FAIL early_pulse got %b want 001", {flush, rif.redirect_valid, busy});
        end
        step();
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL early_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_wrap_and_reset();
        drive(1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h1234, 1'b0, 16'h7777);
        step();
        idle_inputs();
        exp_mp++;
        n_cmp++;
        if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap got rv=%b rpc=%h want 1 0000", rif.redirect_valid, rif.redirect_pc);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_br = 0;
        exp_mp = 0;
        n_cmp++;
        if ({flush, rif.redirect_valid, upd_valid, busy} !== 4'b0000 ||
            rif.redirect_pc !== 16'h0 || branch_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL mid_reset got flags=%b rpc=%h cnt=%0d/%0d want 0000 0000 0/0",
                     {flush, rif.redirect_valid, upd_valid, busy}, rif.redirect_pc, branch_cnt, mispred_cnt);
        end
        drive(1'b1, 1'b1, 16'h0070, 1'b0, 16'h0072, 1'b0, 16'h0010);
        step();
        idle_inputs();
        exp_br++;
        n_cmp++;
        if ({upd_valid, flush, busy} !== 3'b100 || upd_pc !== 16'h0070 ||
            branch_cnt !== 16'h0001 || mispred_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL post_reset got flags=%b pc=%h cnt=%0d/%0d want 100 0070 1/0",
                     {upd_valid, flush, busy}, upd_pc, branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b1, 16'h0200, 1'b1, 16'h0300, 1'b1, 16'h0300);
        while (exp_br < 65534) begin
            step();
            exp_br++;
        end
        n_cmp++;
        if (branch_cnt !== 16'hFFFE || upd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_near got cnt=%h uv=%b want FFFE 1", branch_cnt, upd_valid);
        end
        step();
        n_cmp++;
        if (branch_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_max got %h want FFFF", branch_cnt);
        end
        step();
        step();
        idle_inputs();
        n_cmp++;
        if (branch_cnt !== 16'hFFFF || mispred_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL sat_hold got %h/%h want FFFF/0000", branch_cnt, mispred_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_correct_nt();
        test_non_branch();
        test_dir_mispred();
        test_target_and_wrong_path();
        test_ready_early();
        test_wrap_and_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
